// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - packs decoded RV32I fields into machine words and streams them to instruction memory.
// Optional NOP fill of the remaining memory is built when INSTR_ENCODER_NOP_FILL_EN is defined.
module instr_encoder #(
    parameter int ADDR_W    = 10,
    parameter int DEPTH     = 1024,
    parameter int BASE_ADDR = 0
) (
    input  logic              iClk,
    input  logic              iRstN,
    input  logic              iClear,
`ifdef INSTR_ENCODER_NOP_FILL_EN
    input  logic              iFill,
`endif
    input  logic              iValid,
    output logic              oReady,
    input  logic [2:0]        iClass,
    input  logic [2:0]        iFunct3,
    input  logic              iAlt,
    input  logic [4:0]        iRd,
    input  logic [4:0]        iRs1,
    input  logic [4:0]        iRs2,
    input  logic [31:0]       iImm,
    output logic              oMemValid,
    input  logic              iMemReady,
    output logic [ADDR_W-1:0] oMemAddr,
    output logic [31:0]       oMemData,
    output logic              oFull,
    output logic [ADDR_W:0]   oCount,
    output logic              oIllegal
);

    localparam int                LP_LAST_I  = DEPTH - 1;
    localparam logic [ADDR_W-1:0] LP_LAST    = LP_LAST_I[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] LP_BASE    = BASE_ADDR[ADDR_W-1:0];
    localparam logic [ADDR_W:0]   LP_DEPTH_C = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W+1:0] LP_DEPTH_W = DEPTH[ADDR_W+1:0];
    localparam logic [31:0]       LP_NOP     = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1
`ifdef INSTR_ENCODER_NOP_FILL_EN
        , ST_FILL = 2'd2
`endif
    } state_t;

    state_t            r_state, w_state_n;
    logic [31:0]       r_data, w_data_n;
    logic [ADDR_W-1:0] r_addr, w_addr_n;
    logic [ADDR_W:0]   r_count, w_count_n;
    logic              r_illegal, w_illegal_n;

    logic [31:0]       w_word;
    logic              w_legal;
    logic              w_fit12, w_fit13, w_fit21;
    logic              w_fire, w_accept, w_room_idle, w_room_hold;
    logic [ADDR_W+1:0] w_cnt_p1;
    logic [6:0]        w_funct7;

    assign w_fit12  = (&iImm[31:11]) | ~(|iImm[31:11]);
    assign w_fit13  = (&iImm[31:12]) | ~(|iImm[31:12]);
    assign w_fit21  = (&iImm[31:20]) | ~(|iImm[31:20]);
    assign w_funct7 = iAlt ? 7'h20 : 7'h00;

    always_comb begin
        w_word  = '0;
        w_legal = 1'b0;
        case (iClass)
            3'd0: begin
                w_word  = {w_funct7, iRs2, iRs1, iFunct3, iRd, 7'h33};
                w_legal = !iAlt || (iFunct3 == 3'b000) || (iFunct3 == 3'b101);
            end
            3'd1: begin
                if ((iFunct3 == 3'b001) || (iFunct3 == 3'b101)) begin
                    w_word  = {w_funct7, iImm[4:0], iRs1, iFunct3, iRd, 7'h13};
                    w_legal = w_fit12 && !(iAlt && (iFunct3 == 3'b001));
                end else begin
                    w_word  = {iImm[11:0], iRs1, iFunct3, iRd, 7'h13};
                    w_legal = w_fit12;
                end
            end
            3'd2: begin
                w_word  = {iImm[11:0], iRs1, iFunct3, iRd, 7'h03};
                w_legal = w_fit12 && (iFunct3 != 3'd3) && (iFunct3 != 3'd6) && (iFunct3 != 3'd7);
            end
            3'd3: begin
                w_word  = {iImm[11:5], iRs2, iRs1, iFunct3, iImm[4:0], 7'h23};
                w_legal = w_fit12 && (iFunct3 <= 3'd2);
            end
            3'd4: begin
                w_word  = {iImm[12], iImm[10:5], iRs2, iRs1, iFunct3, iImm[4:1], iImm[11], 7'h63};
                w_legal = w_fit13 && !iImm[0] && (iFunct3 != 3'd2) && (iFunct3 != 3'd3);
            end
            3'd5: begin
                w_word  = {iImm[31:12], iRd, (iFunct3[0] ? 7'h17 : 7'h37)};
                w_legal = 1'b1;
            end
            3'd6: begin
                if (iFunct3[0]) begin
                    w_word  = {iImm[11:0], iRs1, 3'b000, iRd, 7'h67};
                    w_legal = w_fit12;
                end else begin
                    w_word  = {iImm[20], iImm[10:1], iImm[11], iImm[19:12], iRd, 7'h6F};
                    w_legal = w_fit21 && !iImm[0];
                end
            end
            default: begin
                w_word  = '0;
                w_legal = 1'b0;
            end
        endcase
    end

    // Room checks count the word already held, so a new accept can never push past DEPTH.
    assign w_cnt_p1    = {1'b0, r_count} + {{(ADDR_W+1){1'b0}}, 1'b1};
    assign w_room_idle = (r_count != LP_DEPTH_C);
    assign w_room_hold = (w_cnt_p1 < LP_DEPTH_W);
    assign oReady      = !iClear && (((r_state == ST_IDLE) && w_room_idle) ||
                                     ((r_state == ST_HOLD) && iMemReady && w_room_hold));
    assign w_accept    = iValid && oReady;
    assign w_fire      = oMemValid && iMemReady;

    always_comb begin
        w_state_n   = r_state;
        w_data_n    = r_data;
        w_addr_n    = r_addr;
        w_count_n   = r_count;
        w_illegal_n = r_illegal;
        if (iClear) begin
            w_state_n   = ST_IDLE;
            w_addr_n    = LP_BASE;
            w_count_n   = '0;
            w_illegal_n = 1'b0;
        end else begin
            if (w_fire) begin
                w_addr_n  = (r_addr == LP_LAST) ? '0 : r_addr + 1'b1;
                w_count_n = r_count + 1'b1;
                w_state_n = ST_IDLE;
`ifdef INSTR_ENCODER_NOP_FILL_EN
                if ((r_state == ST_FILL) && (w_count_n != LP_DEPTH_C)) begin
                    w_state_n = ST_FILL;
                end
`endif
            end
            if (w_accept) begin
                if (w_legal) begin
                    w_data_n  = w_word;
                    w_state_n = ST_HOLD;
                end else begin
                    w_illegal_n = 1'b1;
                end
            end
`ifdef INSTR_ENCODER_NOP_FILL_EN
            else if ((r_state == ST_IDLE) && iFill && w_room_idle) begin
                w_data_n  = LP_NOP;
                w_state_n = ST_FILL;
            end
`endif
        end
    end

    always_ff @(posedge iClk) begin
        if (!iRstN) begin
            r_state   <= ST_IDLE;
            r_data    <= '0;
            r_addr    <= LP_BASE;
            r_count   <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_data    <= w_data_n;
            r_addr    <= w_addr_n;
            r_count   <= w_count_n;
            r_illegal <= w_illegal_n;
        end
    end

`ifdef INSTR_ENCODER_NOP_FILL_EN
    assign oMemValid = (r_state == ST_HOLD) || (r_state == ST_FILL);
`else
    assign oMemValid = (r_state == ST_HOLD);
`endif
    assign oMemAddr  = r_addr;
    assign oMemData  = r_data;
    assign oCount    = r_count;
    assign oFull     = (r_count == LP_DEPTH_C);
    assign oIllegal  = r_illegal;

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - vector table plus scoreboard bench for instr_encoder (default and DEPTH=4 instances).
module tb_instr_encoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic        m_clear, m_valid, m_ready, m_alt, m_mvalid, m_mready, m_full, m_ill;
    logic [2:0]  m_cls, m_f3;
    logic [4:0]  m_rd, m_rs1, m_rs2;
    logic [31:0] m_imm, m_data;
    logic [9:0]  m_addr;
    logic [10:0] m_count;

    logic        s_clear, s_valid, s_ready, s_alt, s_mvalid, s_mready, s_full, s_ill;
    logic [2:0]  s_cls, s_f3;
    logic [4:0]  s_rd, s_rs1, s_rs2;
    logic [31:0] s_imm, s_data;
    logic [1:0]  s_addr;
    logic [2:0]  s_count;
`ifdef INSTR_ENCODER_NOP_FILL_EN
    logic        m_fill = 1'b0;
    logic        s_fill = 1'b0;
`endif

    instr_encoder u_dut (
        .iClk(clk), .iRstN(rstn), .iClear(m_clear),
`ifdef INSTR_ENCODER_NOP_FILL_EN
        .iFill(m_fill),
`endif
        .iValid(m_valid), .oReady(m_ready), .iClass(m_cls), .iFunct3(m_f3), .iAlt(m_alt),
        .iRd(m_rd), .iRs1(m_rs1), .iRs2(m_rs2), .iImm(m_imm),
        .oMemValid(m_mvalid), .iMemReady(m_mready), .oMemAddr(m_addr), .oMemData(m_data),
        .oFull(m_full), .oCount(m_count), .oIllegal(m_ill)
    );

    instr_encoder #(.ADDR_W(2), .DEPTH(4), .BASE_ADDR(1)) u_small (
        .iClk(clk), .iRstN(rstn), .iClear(s_clear),
`ifdef INSTR_ENCODER_NOP_FILL_EN
        .iFill(s_fill),
`endif
        .iValid(s_valid), .oReady(s_ready), .iClass(s_cls), .iFunct3(s_f3), .iAlt(s_alt),
        .iRd(s_rd), .iRs1(s_rs1), .iRs2(s_rs2), .iImm(s_imm),
        .oMemValid(s_mvalid), .iMemReady(s_mready), .oMemAddr(s_addr), .oMemData(s_data),
        .oFull(s_full), .oCount(s_count), .oIllegal(s_ill)
    );

    typedef struct {
        logic [2:0]  cls;
        logic [2:0]  f3;
        logic        alt;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        legal;
        logic [31:0] word;
    } vec_t;

    typedef struct {
        logic [9:0]  addr;
        logic [31:0] data;
    } exp_t;

    localparam int N_VEC   = 21;
    localparam int N_LEGAL = 13;

    vec_t       vecs[N_VEC];
    exp_t       sb[$];
    logic [9:0] exp_addr;
    logic [1:0] s_exp_addr;
    int         n_cmp = 0;
    int         n_err = 0;
    int         n_pop = 0;
    int         s_n_acc = 0;
    int         s_n_wr = 0;

    function automatic vec_t mk(input logic [2:0] c, input logic [2:0] f, input logic a,
                                input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [31:0] imm, input logic lg, input logic [31:0] w);
        vec_t v;
        v.cls = c; v.f3 = f; v.alt = a; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        v.imm = imm; v.legal = lg; v.word = w;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cycle(output logic acc);
        exp_t e;
        @(negedge clk);
        if (m_mvalid && m_mready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb_unexpected: got write %h at %h expected none", m_data, m_addr);
            end else begin
                e = sb.pop_front();
                check("sb_addr", 32'(m_addr), 32'(e.addr));
                check("sb_data", m_data, e.data);
                n_pop++;
            end
        end
        if (s_mvalid && s_mready) begin
            check("small_addr", 32'(s_addr), 32'(s_exp_addr));
            s_exp_addr = s_exp_addr + 2'd1;
            s_n_wr++;
        end
        if (s_valid && s_ready) s_n_acc++;
        acc = m_valid && m_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input vec_t v, output int waits);
        logic acc;
        exp_t e;
        m_cls = v.cls; m_f3 = v.f3; m_alt = v.alt; m_rd = v.rd;
        m_rs1 = v.rs1; m_rs2 = v.rs2; m_imm = v.imm; m_valid = 1'b1;
        waits = 0;
        acc = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycle(acc);
            if (acc) break;
            waits++;
        end
        if (!acc) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: got no accept expected accept within 20 cycles");
        end else if (v.legal) begin
            e.addr = exp_addr;
            e.data = v.word;
            sb.push_back(e);
            exp_addr = exp_addr + 10'd1;
        end
    endtask

    task automatic drain();
        logic acc;
        m_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (sb.size() == 0 && !m_mvalid) break;
            cycle(acc);
        end
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        logic acc;
        int   w, wsum, p0;
        vecs[0]  = mk(3'd0, 3'd0, 1'b0, 5'd1, 5'd2, 5'd3, 32'd0,          1'b1, 32'h003100B3);
        vecs[1]  = mk(3'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5,          1'b1, 32'h00500093);
        vecs[2]  = mk(3'd0, 3'd0, 1'b1, 5'd5, 5'd6, 5'd7, 32'd0,          1'b1, 32'h407302B3);
        vecs[3]  = mk(3'd3, 3'd2, 1'b0, 5'd0, 5'd2, 5'd5, 32'd8,          1'b1, 32'h00512423);
        vecs[4]  = mk(3'd4, 3'd0, 1'b0, 5'd9, 5'd0, 5'd0, 32'hFFFFFFFC,   1'b1, 32'hFE000EE3);
        vecs[5]  = mk(3'd5, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h12345000,   1'b1, 32'h123450B7);
        vecs[6]  = mk(3'd2, 3'd2, 1'b0, 5'd3, 5'd4, 5'd0, 32'hFFFFFFFF,   1'b1, 32'hFFF22183);
        vecs[7]  = mk(3'd1, 3'd5, 1'b1, 5'd1, 5'd2, 5'd0, 32'd3,          1'b1, 32'h40315093);
        vecs[8]  = mk(3'd6, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8,          1'b1, 32'h008000EF);
        vecs[9]  = mk(3'd6, 3'd1, 1'b0, 5'd0, 5'd1, 5'd0, 32'd0,          1'b1, 32'h00008067);
        vecs[10] = mk(3'd5, 3'd1, 1'b0, 5'd5, 5'd0, 5'd0, 32'hFFFFF000,   1'b1, 32'hFFFFF297);
        vecs[11] = mk(3'd4, 3'd1, 1'b0, 5'd0, 5'd1, 5'd2, 32'd4094,       1'b1, 32'h7E209FE3);
        vecs[12] = mk(3'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'hFFFFF800,   1'b1, 32'h80000093);
        vecs[13] = mk(3'd7, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd0,          1'b0, 32'h0);
        vecs[14] = mk(3'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048,       1'b0, 32'h0);
        vecs[15] = mk(3'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd3,          1'b0, 32'h0);
        vecs[16] = mk(3'd2, 3'd3, 1'b0, 5'd1, 5'd2, 5'd0, 32'd0,          1'b0, 32'h0);
        vecs[17] = mk(3'd6, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h00100000,   1'b0, 32'h0);
        vecs[18] = mk(3'd1, 3'd1, 1'b1, 5'd1, 5'd2, 5'd0, 32'd1,          1'b0, 32'h0);
        vecs[19] = mk(3'd0, 3'd1, 1'b1, 5'd1, 5'd2, 5'd3, 32'd0,          1'b0, 32'h0);
        vecs[20] = mk(3'd4, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd4,          1'b0, 32'h0);

        rstn = 1'b0;
        m_clear = 1'b0; m_valid = 1'b0; m_mready = 1'b1;
        m_cls = '0; m_f3 = '0; m_alt = 1'b0; m_rd = '0; m_rs1 = '0; m_rs2 = '0; m_imm = '0;
        s_clear = 1'b0; s_valid = 1'b0; s_mready = 1'b1;
        s_cls = 3'd1; s_f3 = '0; s_alt = 1'b0; s_rd = 5'd1; s_rs1 = '0; s_rs2 = '0; s_imm = 32'd5;
        exp_addr = 10'd0;
        s_exp_addr = 2'd1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_valid", 32'(m_mvalid), 32'd0);
        check("rst_data", m_data, 32'd0);
        check("rst_addr", 32'(m_addr), 32'd0);
        check("rst_count", 32'(m_count), 32'd0);
        check("rst_illegal", 32'(m_ill), 32'd0);
        check("rst_full", 32'(m_full), 32'd0);
        check("rst_small_addr", 32'(s_addr), 32'd1);
        rstn = 1'b1;
        #1;
        check("rst_ready", 32'(m_ready), 32'd1);

        send(vecs[0], w);
        drain();
        check("first_count", 32'(m_count), 32'd1);

        m_clear = 1'b1;
        cycle(acc);
        m_clear = 1'b0;
        exp_addr = 10'd0;
        wsum = 0;
        p0 = n_pop;
        for (int i = 1; i <= 3; i++) begin
            send(vecs[i], w);
            wsum += w;
        end
        m_valid = 1'b0;
        cycle(acc);
        check("stream_waits", 32'(wsum), 32'd0);
        check("stream_pops", 32'(n_pop - p0), 32'd3);
        check("stream_count", 32'(m_count), 32'd3);

        m_mready = 1'b0;
        send(vecs[4], w);
        m_cls = vecs[5].cls; m_f3 = vecs[5].f3; m_rd = vecs[5].rd; m_imm = vecs[5].imm;
        m_rs1 = 5'd0; m_rs2 = 5'd0; m_alt = 1'b0; m_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_valid", 32'(m_mvalid), 32'd1);
            check("stall_data", m_data, 32'hFE000EE3);
            check("stall_addr", 32'(m_addr), 32'd3);
            check("stall_ready", 32'(m_ready), 32'd0);
            cycle(acc);
        end
        m_mready = 1'b1;
        send(vecs[5], w);
        check("stall_release_waits", 32'(w), 32'd0);

        for (int i = 6; i < N_LEGAL; i++) send(vecs[i], w);
        drain();
        check("table_count", 32'(m_count), 32'(exp_addr));

        p0 = int'(m_count);
        for (int i = N_LEGAL; i < N_VEC; i++) begin
            send(vecs[i], w);
            m_valid = 1'b0;
            cycle(acc);
            check("illegal_flag", 32'(m_ill), 32'd1);
            check("illegal_no_write", 32'(m_mvalid), 32'd0);
            check("illegal_count", 32'(m_count), 32'(p0));
        end
        m_clear = 1'b1;
        cycle(acc);
        m_clear = 1'b0;
        check("clear_illegal", 32'(m_ill), 32'd0);
        check("clear_count", 32'(m_count), 32'd0);
        check("clear_addr", 32'(m_addr), 32'd0);

        s_valid = 1'b1;
        for (int i = 0; i < 12; i++) cycle(acc);
        s_valid = 1'b0;
        #1;
        check("small_accepts", 32'(s_n_acc), 32'd4);
        check("small_writes", 32'(s_n_wr), 32'd4);
        check("small_count", 32'(s_count), 32'd4);
        check("small_full", 32'(s_full), 32'd1);
        check("small_ready_full", 32'(s_ready), 32'd0);
        check("small_addr_wrap", 32'(s_addr), 32'd1);

        s_clear = 1'b1;
        cycle(acc);
        s_clear = 1'b0;
        s_exp_addr = 2'd1;
        s_mready = 1'b0;
        s_valid = 1'b1;
        cycle(acc);
        s_valid = 1'b0;
        check("small_hold", 32'(s_mvalid), 32'd1);
        s_clear = 1'b1;
        cycle(acc);
        s_clear = 1'b0;
        check("clr_hold_valid", 32'(s_mvalid), 32'd0);
        check("clr_hold_addr", 32'(s_addr), 32'd1);
        check("clr_hold_count", 32'(s_count), 32'd0);

        s_cls = 3'd7;
        s_valid = 1'b1;
        cycle(acc);
        s_cls = 3'd1;
        cycle(acc);
        s_valid = 1'b0;
        check("pre_rst_hold", 32'(s_mvalid), 32'd1);
        check("pre_rst_illegal", 32'(s_ill), 32'd1);
        rstn = 1'b0;
        cycle(acc);
        check("mid_rst_valid", 32'(s_mvalid), 32'd0);
        check("mid_rst_data", s_data, 32'd0);
        check("mid_rst_addr", 32'(s_addr), 32'd1);
        check("mid_rst_count", 32'(s_count), 32'd0);
        check("mid_rst_illegal", 32'(s_ill), 32'd0);
        check("mid_rst_full", 32'(s_full), 32'd0);
        rstn = 1'b1;
        cycle(acc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
